// File: rtl/specific_seq_checker.sv
// rtl/specific_seq_checker.sv - lock/flywheel checker for the 0,2,5,8,11,14 sequence stream
//
// Purpose: watches a sampled 4-bit sequence value, acquires lock after
// LOCK_COUNT consecutive in-sequence samples, flags and counts mismatches
// while locked, and drops lock after UNLOCK_ERRS consecutive mismatches.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   in_valid   in   qualifies in_value this cycle
//   in_value   in   [3:0] sampled sequence value
//   clr_count  in   synchronous clear of err_count (wins over an increment)
//   locked     out  checker is in LOCKED state
//   error      out  one-cycle pulse, mismatch while locked
//   seq_ok     out  one-cycle pulse, sample matched expected in SYNC/LOCKED
//   expected   out  [3:0] next value the checker expects
//   err_count  out  [ERR_W-1:0] saturating error count

module specific_seq_checker #(
   parameter int LOCK_COUNT  = 3,
   parameter int UNLOCK_ERRS = 2,
   parameter int ERR_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [3:0]       in_value,
   input  logic             clr_count,
   output logic             locked,
   output logic             error,
   output logic             seq_ok,
   output logic [3:0]       expected,
   output logic [ERR_W-1:0] err_count
);

   localparam int GW = (LOCK_COUNT  < 1) ? 1 : $clog2(LOCK_COUNT + 1);
   localparam int BW = (UNLOCK_ERRS < 1) ? 1 : $clog2(UNLOCK_ERRS + 1);

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_SYNC   = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   state_t           state_q,     state_d;
   logic [3:0]       expected_q,  expected_d;
   logic [GW-1:0]    good_run_q,  good_run_d;
   logic [BW-1:0]    bad_run_q,   bad_run_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;
   logic             error_q,     error_d;
   logic             seq_ok_q,    seq_ok_d;

   logic [GW-1:0]    good_inc;
   logic [BW-1:0]    bad_inc;

   function automatic logic is_legal(input logic [3:0] v);
      case (v)
         4'd0, 4'd2, 4'd5, 4'd8, 4'd11, 4'd14: is_legal = 1'b1;
         default:                              is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] succ(input logic [3:0] v);
      case (v)
         4'd0:    succ = 4'd2;
         4'd2:    succ = 4'd5;
         4'd5:    succ = 4'd8;
         4'd8:    succ = 4'd11;
         4'd11:   succ = 4'd14;
         default: succ = 4'd0;   // 14 wraps to 0; illegal values never reach here
      endcase
   endfunction

   assign good_inc = good_run_q + GW'(1);
   assign bad_inc  = bad_run_q + BW'(1);

   always_comb begin
      state_d     = state_q;
      expected_d  = expected_q;
      good_run_d  = good_run_q;
      bad_run_d   = bad_run_q;
      err_count_d = err_count_q;
      error_d     = 1'b0;
      seq_ok_d    = 1'b0;

      if (in_valid) begin
         case (state_q)
            ST_HUNT: begin
               if (is_legal(in_value)) begin
                  expected_d = succ(in_value);
                  good_run_d = GW'(1);
                  if (LOCK_COUNT == 1) begin
                     state_d   = ST_LOCKED;
                     bad_run_d = '0;
                  end else begin
                     state_d = ST_SYNC;
                  end
               end
            end

            ST_SYNC: begin
               if (in_value == expected_q) begin
                  seq_ok_d   = 1'b1;
                  expected_d = succ(expected_q);
                  good_run_d = good_inc;
                  if (good_inc == GW'(LOCK_COUNT)) begin
                     state_d   = ST_LOCKED;
                     bad_run_d = '0;
                  end
               end else if (is_legal(in_value)) begin
                  // re-seed the run from the legal sample just seen
                  expected_d = succ(in_value);
                  good_run_d = GW'(1);
               end else begin
                  state_d    = ST_HUNT;
                  good_run_d = '0;
               end
            end

            ST_LOCKED: begin
               if (in_value == expected_q) begin
                  seq_ok_d   = 1'b1;
                  expected_d = succ(expected_q);
                  bad_run_d  = '0;
               end else begin
                  error_d = 1'b1;
                  if (err_count_q != {ERR_W{1'b1}}) begin
                     err_count_d = err_count_q + ERR_W'(1);
                  end
                  // flywheel: keep advancing so a single glitch does not slip the stream
                  expected_d = succ(expected_q);
                  bad_run_d  = bad_inc;
                  if (bad_inc == BW'(UNLOCK_ERRS)) begin
                     state_d    = ST_HUNT;
                     good_run_d = '0;
                     bad_run_d  = '0;
                  end
               end
            end

            default: begin
               state_d = ST_HUNT;
            end
         endcase
      end

      if (clr_count) begin
         err_count_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_HUNT;
         expected_q  <= 4'd0;
         good_run_q  <= '0;
         bad_run_q   <= '0;
         err_count_q <= '0;
         error_q     <= 1'b0;
         seq_ok_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         expected_q  <= expected_d;
         good_run_q  <= good_run_d;
         bad_run_q   <= bad_run_d;
         err_count_q <= err_count_d;
         error_q     <= error_d;
         seq_ok_q    <= seq_ok_d;
      end
   end

   assign locked    = (state_q == ST_LOCKED);
   assign error     = error_q;
   assign seq_ok    = seq_ok_q;
   assign expected  = expected_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_specific_seq_checker.sv
// tb/tb_specific_seq_checker.sv - scoreboard bench for specific_seq_checker

module tb_specific_seq_checker;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] in_value = 4'd0;
   logic       clr_count = 1'b0;
   logic       locked, error, seq_ok;
   logic [3:0] expected;
   logic [7:0] err_count;

   specific_seq_checker #(.LOCK_COUNT(3), .UNLOCK_ERRS(2), .ERR_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_value  (in_value),
      .clr_count (clr_count),
      .locked    (locked),
      .error     (error),
      .seq_ok    (seq_ok),
      .expected  (expected),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       l;
      logic       e;
      logic       ok;
      logic [3:0] x;
      logic [7:0] c;
      int         due;
      int         tag;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   tag_n = 0;
   int   checks = 0;
   int   failures = 0;
   logic [3:0] seq_tab [6] = '{4'd0, 4'd2, 4'd5, 4'd8, 4'd11, 4'd14};

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: pops the expectation whose sampling edge has passed
   always @(negedge clk) begin
      if (q.size() > 0 && q[0].due <= cyc) begin
         exp_t it;
         it = q.pop_front();
         checks++;
         if (locked !== it.l || error !== it.e || seq_ok !== it.ok ||
             expected !== it.x || err_count !== it.c) begin
            failures++;
            $display("FAIL step%0d: got locked=%b error=%b seq_ok=%b expected=%0d err_count=%0d, want locked=%b error=%b seq_ok=%b expected=%0d err_count=%0d",
                     it.tag, locked, error, seq_ok, expected, err_count,
                     it.l, it.e, it.ok, it.x, it.c);
         end
      end
   end

   task automatic step(input logic v, input logic [3:0] val, input logic clr,
                       input logic el, input logic ee, input logic eok,
                       input logic [3:0] ex, input logic [7:0] ec);
      exp_t it;
      @(posedge clk);
      #2;
      in_valid  = v;
      in_value  = val;
      clr_count = clr;
      it.l = el; it.e = ee; it.ok = eok; it.x = ex; it.c = ec;
      it.due = cyc + 1;
      it.tag = tag_n;
      tag_n++;
      q.push_back(it);
   endtask

   task automatic drain();
      for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
         q.delete();
      end
   endtask

   task automatic check_now(input string name, input logic el, input logic [3:0] ex,
                            input logic [7:0] ec);
      checks++;
      if (locked !== el || error !== 1'b0 || seq_ok !== 1'b0 ||
          expected !== ex || err_count !== ec) begin
         failures++;
         $display("FAIL %s: got locked=%b error=%b seq_ok=%b expected=%0d err_count=%0d, want locked=%b error=0 seq_ok=0 expected=%0d err_count=%0d",
                  name, locked, error, seq_ok, expected, err_count, el, ex, ec);
      end
   endtask

   // asynchronous reset pulse placed between clock edges
   task automatic reset_mid(input string name);
      drain();
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_now(name, 1'b0, 4'd0, 8'd0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      int idx;
      int cnt;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_now("reset_state", 1'b0, 4'd0, 8'd0);
      reset = 1'b0;

      // acquisition: 0,0,2,5 then clean stream
      step(1, 4'd0,  0, 0, 0, 0, 4'd2,  8'd0);
      step(1, 4'd0,  0, 0, 0, 0, 4'd2,  8'd0);
      step(1, 4'd2,  0, 0, 0, 1, 4'd5,  8'd0);
      step(1, 4'd5,  0, 1, 0, 1, 4'd8,  8'd0);
      step(1, 4'd8,  0, 1, 0, 1, 4'd11, 8'd0);
      step(1, 4'd11, 0, 1, 0, 1, 4'd14, 8'd0);
      step(1, 4'd14, 0, 1, 0, 1, 4'd0,  8'd0);
      step(1, 4'd0,  0, 1, 0, 1, 4'd2,  8'd0);
      step(1, 4'd2,  0, 1, 0, 1, 4'd5,  8'd0);
      step(1, 4'd5,  0, 1, 0, 1, 4'd8,  8'd0);

      // single bad sample, flywheel keeps lock
      step(1, 4'd7,  0, 1, 1, 0, 4'd11, 8'd1);
      step(1, 4'd11, 0, 1, 0, 1, 4'd14, 8'd1);
      step(1, 4'd14, 0, 1, 0, 1, 4'd0,  8'd1);
      step(1, 4'd0,  0, 1, 0, 1, 4'd2,  8'd1);

      // clear count on a good sample, then two bad samples drop lock
      step(1, 4'd2,  1, 1, 0, 1, 4'd5,  8'd0);
      step(1, 4'd7,  0, 1, 1, 0, 4'd8,  8'd1);
      step(1, 4'd7,  0, 0, 1, 0, 4'd11, 8'd2);
      step(1, 4'd0,  0, 0, 0, 0, 4'd2,  8'd2);
      step(1, 4'd2,  0, 0, 0, 1, 4'd5,  8'd2);
      step(1, 4'd5,  0, 1, 0, 1, 4'd8,  8'd2);

      // illegal values in HUNT, then SYNC illegal drops back to HUNT
      step(0, 4'd0,  0, 1, 0, 0, 4'd8,  8'd2);
      reset_mid("reset_before_hunt");
      step(1, 4'd1,  0, 0, 0, 0, 4'd0,  8'd0);
      step(1, 4'd3,  0, 0, 0, 0, 4'd0,  8'd0);
      step(1, 4'd4,  0, 0, 0, 0, 4'd0,  8'd0);
      step(1, 4'd15, 0, 0, 0, 0, 4'd0,  8'd0);
      step(1, 4'd5,  0, 0, 0, 0, 4'd8,  8'd0);
      step(1, 4'd6,  0, 0, 0, 0, 4'd8,  8'd0);
      step(1, 4'd8,  0, 0, 0, 0, 4'd11, 8'd0);
      step(1, 4'd11, 0, 0, 0, 1, 4'd14, 8'd0);
      step(1, 4'd14, 0, 1, 0, 1, 4'd0,  8'd0);

      // saturation: alternate bad/good so lock is held
      idx = 0;
      for (int i = 1; i <= 259; i++) begin
         cnt = (i > 255) ? 255 : i;
         idx = (idx + 1) % 6;
         step(1, 4'd1, 0, 1, 1, 0, seq_tab[idx], cnt[7:0]);
         step(1, seq_tab[idx], 0, 1, 0, 1, seq_tab[(idx + 1) % 6], cnt[7:0]);
         idx = (idx + 1) % 6;
      end
      // clear coincident with an error: clear wins, pulse still fires
      idx = (idx + 1) % 6;
      step(1, 4'd1, 1, 1, 1, 0, seq_tab[idx], 8'd0);
      step(1, seq_tab[idx], 0, 1, 0, 1, seq_tab[(idx + 1) % 6], 8'd0);
      idx = (idx + 1) % 6;

      // in_valid toggling holds state, then reset mid-stream
      step(1, seq_tab[idx], 0, 1, 0, 1, seq_tab[(idx + 1) % 6], 8'd0);
      idx = (idx + 1) % 6;
      step(0, 4'd9,         0, 1, 0, 0, seq_tab[idx], 8'd0);
      step(1, seq_tab[idx], 0, 1, 0, 1, seq_tab[(idx + 1) % 6], 8'd0);
      idx = (idx + 1) % 6;
      step(0, 4'd9,         0, 1, 0, 0, seq_tab[idx], 8'd0);
      reset_mid("reset_mid_stream");

      // recovery after reset
      step(1, 4'd5,  0, 0, 0, 0, 4'd8,  8'd0);
      step(0, 4'd0,  0, 0, 0, 0, 4'd8,  8'd0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, want finish before 200000");
      $fatal(1, "timeout");
   end

endmodule
